lcd_msg_encoder: RTL and testbench
==================================

Name: lcd_msg_encoder

Overview:
- Parametrised, streaming successor to the opcode-to-LCD-word encoder.
- On a start pulse it latches opcode, destination register index and a signed result value.
- It emits the full HD44780 byte sequence (mnemonic, destination in binary, signed decimal value on line 2) one byte at a time, each with its RS bit, over a valid/ready handshake.
- Sits between the CPU control unit and the LCD driver FSM.

Parameters:
- DEST_W, 4, destination index width; printed as DEST_W binary chars.
- VAL_W, 8, signed value width (two's complement).
- DIGITS, 3, decimal digits printed for |valor|; must satisfy 10^DIGITS > 2^(VAL_W-1).
- DEST_COL, 9, line-1 column of '['; cursor cmd = 0x80|DEST_COL.
- SHOW_VALUE, 1, 1 = print line-2 value field; 0 = omit it and skip conversion.

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- start in 1: request; sampled only when busy=0.
- opcode in 3: LOAD=0 ADD=1 ADDI=2 SUB=3 SUBI=4 MUL=5 CLEAR=6 DPL=7.
- destino in DEST_W: destination register index.
- valor in VAL_W: signed result to display.
- busy out 1: message in progress.
- out_valid out 1: out_data/out_rs valid.
- out_data out 8: LCD byte.
- out_rs out 1: 1 = data/char, 0 = command.
- out_last out 1: marks final byte of the message.
- out_ready in 1: consumer accepts the byte.
- done out 1: one-cycle pulse after the last transfer.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, out_last, done, out_rs = 0; out_data = 0x00. Reset mid-message aborts it; no partial resume.
- IDLE: start=1 latches opcode, destino and valor. Next state is CONV if SHOW_VALUE=1 and opcode!=CLEAR, otherwise EMIT. busy rises the next cycle.
- start while busy=1 is ignored; the latched inputs do not change.
- CONV: magnitude = valor<0 ? -valor : valor, computed in VAL_W+1 bits so -2^(VAL_W-1) is correct. Sequential double-dabble takes exactly VAL_W cycles, then EMIT.
- Latency: first out_valid appears VAL_W+1 cycles after the start cycle (with conversion), or 1 cycle after (without).
- EMIT: byte index counter walks the sequence.
- Transfer happens when out_valid & out_ready. out_data, out_rs and out_last stay stable while out_valid=1 and out_ready=0.
- With out_ready held high, the block emits one byte per cycle.
- Mnemonic bytes are ASCII, RS=1: LOAD, ADD, ADDI, SUB, SUBI, MUL, CLEAR, DPL.
- Non-CLEAR sequence:
  - mnemonic;
  - 0x80|DEST_COL (RS=0);
  - '[' (RS=1);
  - DEST_W chars '0'/'1', MSB first (RS=1);
  - ']' (RS=1);
  - if SHOW_VALUE: 0xC0 (RS=0), sign '-' (0x2D) if negative else '+' (0x2B), then DIGITS digits MSD first with leading zeros (RS=1);
  - 0x02 home (RS=0), flagged out_last.
- CLEAR sequence: 0x01 clear (RS=0), "CLEAR" (RS=1), 0x02 (RS=0, out_last).
- After the out_last transfer:
  - next cycle: done=1, busy=0, out_valid=0, state IDLE;
  - a start in that same cycle is accepted.
- Byte count = len(mnemonic) + DEST_W + 4 + (SHOW_VALUE ? DIGITS+2 : 0). CLEAR is always 7.

Decomposition:
- Shared package lcd_pkg:
  - opcode localparams;
  - ASCII/command constants (CMD_CLEAR 0x01, CMD_HOME 0x02, CMD_LINE2 0xC0, CMD_DDRAM 0x80);
  - mnemonic lookup function returning chars and length.
- One sub-module bin2bcd_seq (parameters VAL_W, DIGITS), with start/busy/done handshake and a DIGITS*4-bit BCD output.

Test Plan:
- LOAD, destino=4'b1010, valor=8'hF3, out_ready=1 -> 17 bytes:
  - data 4C 4F 41 44 89 5B 31 30 31 30 5D C0 2D 30 31 33 02;
  - RS 1111 0 111111 0 1111 0;
  - out_last only on 02; done pulse 1 cycle later.
- CLEAR, any destino/valor -> 01 43 4C 45 41 52 02 with RS 0 11111 0; first out_valid 1 cycle after start (no CONV).
- ADD, destino=3, valor=127 with out_ready toggled every other cycle:
  - bytes 41 44 44 89 5B 30 30 31 31 5D C0 2B 31 32 37 02;
  - held bytes stable during stalls; no duplicates or drops.
- SUBI, valor=8'h80 -> value field 2D 31 32 38 ("-128"); DPL, valor=0 -> 2B 30 30 30.
- Second start mid-message (different opcode) -> ignored; first message completes unchanged. New start in the done cycle -> accepted; busy back high next cycle.
- rst_n low during EMIT byte 6 -> all outputs 0 immediately; after release, a new LOAD yields its full 17-byte sequence from byte 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - opcodes, HD44780 byte constants and mnemonic lookup for the LCD message encoder
package lcd_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SUBI  = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;
    localparam logic [2:0] OP_DPL   = 3'd7;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_ONE    = 8'h31;

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_EMIT} state_t;

    // chars is left-aligned: first character in bits [39:32]
    typedef struct packed {
        logic [39:0] chars;
        logic [2:0]  len;
    } mnem_t;

    function automatic mnem_t mnemonic(input logic [2:0] op);
        mnem_t m;
        case (op)
            OP_LOAD:  m = '{chars: 40'h4C4F414400, len: 3'd4};
            OP_ADD:   m = '{chars: 40'h4144440000, len: 3'd3};
            OP_ADDI:  m = '{chars: 40'h4144444900, len: 3'd4};
            OP_SUB:   m = '{chars: 40'h5355420000, len: 3'd3};
            OP_SUBI:  m = '{chars: 40'h5355424900, len: 3'd4};
            OP_MUL:   m = '{chars: 40'h4D554C0000, len: 3'd3};
            OP_CLEAR: m = '{chars: 40'h434C454152, len: 3'd5};
            default:  m = '{chars: 40'h44504C0000, len: 3'd3};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_msg_encoder_if.sv
// rtl/lcd_msg_encoder_if.sv - request and byte-stream signals between control unit, encoder and LCD driver
interface lcd_msg_encoder_if #(
    parameter int DEST_W = 4,
    parameter int VAL_W  = 8
);
    logic              start;
    logic [2:0]        opcode;
    logic [DEST_W-1:0] destino;
    logic [VAL_W-1:0]  valor;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_rs;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  start, opcode, destino, valor, out_ready,
        output busy, done, out_valid, out_data, out_rs, out_last
    );

    modport slave (
        output start, opcode, destino, valor, out_ready,
        input  busy, done, out_valid, out_data, out_rs, out_last
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per cycle, VAL_W cycles per conversion
module bin2bcd_seq #(
    parameter int VAL_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    sh_q;
    logic [DIGITS*4-1:0] bcd_q;
    logic [DIGITS*4-1:0] adj;
    logic [CNT_W-1:0]    cnt_q;

    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start && !busy) begin
            sh_q  <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(VAL_W);
        end else if (busy) begin
            bcd_q <= {adj[DIGITS*4-2:0], sh_q[VAL_W-1]};
            sh_q  <= {sh_q[VAL_W-2:0], 1'b0};
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // done marks the final shift cycle; bcd holds the result from the next cycle on
    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_msg_encoder.sv
// rtl/lcd_msg_encoder.sv - streams the HD44780 byte sequence for one opcode/destination/value message
module lcd_msg_encoder
    import lcd_pkg::*;
#(
    parameter int DEST_W     = 4,
    parameter int VAL_W      = 8,
    parameter int DIGITS     = 3,
    parameter int DEST_COL   = 9,
    parameter int SHOW_VALUE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_msg_encoder_if.master   bus
);
    state_t              state_q, state_d;
    logic [7:0]          idx_q;
    logic [2:0]          op_q;
    logic [DEST_W-1:0]   dest_q;
    logic                neg_q;
    logic                done_q;
    logic                accept, xfer, need_conv;
    logic [VAL_W-1:0]    mag;
    logic                cv_busy, cv_done;
    logic [DIGITS*4-1:0] bcd;
    mnem_t               mn;
    logic [7:0]          byte_data;
    logic                byte_rs, byte_last;
    int                  rel, cidx, mlen, dpos, vpos, last_pos;
    logic [39:0]         csh;
    logic [DEST_W-1:0]   dsh;
    logic [DIGITS*4-1:0] bsh;

    assign need_conv = (SHOW_VALUE != 0) && (bus.opcode != OP_CLEAR);
    assign mag       = bus.valor[VAL_W-1] ? (~bus.valor + VAL_W'(1)) : bus.valor;

    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && need_conv),
        .bin   (mag),
        .busy  (cv_busy),
        .done  (cv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                accept  = 1'b1;
                state_d = need_conv ? ST_CONV : ST_EMIT;
            end
            ST_CONV: if (cv_done || !cv_busy) state_d = ST_EMIT;
            ST_EMIT: if (bus.out_ready) begin
                xfer = 1'b1;
                if (byte_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= xfer && byte_last;
            if (accept) begin
                op_q   <= bus.opcode;
                dest_q <= bus.destino;
                neg_q  <= bus.valor[VAL_W-1];
                idx_q  <= '0;
            end else if (xfer) begin
                idx_q  <= idx_q + 8'd1;
            end
        end
    end

    assign mn = mnemonic(op_q);

    // Byte positions: mnemonic, cursor, '[', dest bits from dpos, ']', then line-2 field from vpos
    always_comb begin
        byte_data = 8'h00;
        byte_rs   = 1'b0;
        byte_last = 1'b0;
        rel       = 32'(idx_q);
        mlen      = 32'(mn.len);
        cidx      = (op_q == OP_CLEAR) ? rel - 1 : rel;
        dpos      = mlen + 2;
        vpos      = dpos + DEST_W + 1;
        last_pos  = (SHOW_VALUE != 0) ? vpos + DIGITS + 2 : vpos;
        csh       = mn.chars << (8 * cidx);
        dsh       = dest_q << (rel - dpos);
        bsh       = bcd << (4 * (rel - vpos - 2));
        if (state_q == ST_EMIT) begin
            if (op_q == OP_CLEAR) begin
                if (rel == 0) begin
                    byte_data = CMD_CLEAR;
                end else if (rel == mlen + 1) begin
                    byte_data = CMD_HOME;
                    byte_last = 1'b1;
                end else begin
                    byte_data = csh[39:32];
                    byte_rs   = 1'b1;
                end
            end else if (rel < mlen) begin
                byte_data = csh[39:32];
                byte_rs   = 1'b1;
            end else if (rel == mlen) begin
                byte_data = CMD_DDRAM | 8'(DEST_COL);
            end else if (rel == mlen + 1) begin
                byte_data = CH_LBRACK;
                byte_rs   = 1'b1;
            end else if (rel < dpos + DEST_W) begin
                byte_data = dsh[DEST_W-1] ? CH_ONE : CH_ZERO;
                byte_rs   = 1'b1;
            end else if (rel == dpos + DEST_W) begin
                byte_data = CH_RBRACK;
                byte_rs   = 1'b1;
            end else if (rel == last_pos) begin
                byte_data = CMD_HOME;
                byte_last = 1'b1;
            end else if (rel == vpos) begin
                byte_data = CMD_LINE2;
            end else if (rel == vpos + 1) begin
                byte_data = neg_q ? CH_MINUS : CH_PLUS;
                byte_rs   = 1'b1;
            end else begin
                byte_data = CH_ZERO | {4'h0, bsh[DIGITS*4-1 -: 4]};
                byte_rs   = 1'b1;
            end
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = (state_q == ST_EMIT);
    assign bus.out_data  = byte_data;
    assign bus.out_rs    = byte_rs;
    assign bus.out_last  = byte_last;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_lcd_msg_encoder.sv
// tb/tb_lcd_msg_encoder.sv - scoreboard bench for lcd_msg_encoder with a string-level message model
module tb_lcd_msg_encoder;
    localparam int DEST_W     = 4;
    localparam int VAL_W      = 8;
    localparam int DIGITS     = 3;
    localparam int DEST_COL   = 9;
    localparam int SHOW_VALUE = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_msg_encoder_if #(.DEST_W(DEST_W), .VAL_W(VAL_W)) bus ();

    lcd_msg_encoder #(
        .DEST_W(DEST_W), .VAL_W(VAL_W), .DIGITS(DIGITS),
        .DEST_COL(DEST_COL), .SHOW_VALUE(SHOW_VALUE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         xfers    = 0;
    int         ready_mode = 0;
    logic [9:0] exp_q[$];
    logic       exp_done = 1'b0;
    logic       stalled  = 1'b0;
    logic [9:0] held;
    string      mn[8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DPL"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or no data expected", name);
    endtask

    function automatic void push_b(input logic [7:0] d, input logic rs, input logic last);
        exp_q.push_back({d, rs, last});
    endfunction

    function automatic void push_msg(input int op, input int dest, input int val);
        string s;
        int    mag;
        s = mn[op];
        if (op == 6) begin
            push_b(8'h01, 1'b0, 1'b0);
            for (int i = 0; i < s.len(); i++) push_b(s[i], 1'b1, 1'b0);
            push_b(8'h02, 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < s.len(); i++) push_b(s[i], 1'b1, 1'b0);
        push_b(8'h80 | 8'(DEST_COL), 1'b0, 1'b0);
        push_b("[", 1'b1, 1'b0);
        for (int b = DEST_W - 1; b >= 0; b--) push_b(((dest >> b) & 1) != 0 ? "1" : "0", 1'b1, 1'b0);
        push_b("]", 1'b1, 1'b0);
        if (SHOW_VALUE != 0) begin
            push_b(8'hC0, 1'b0, 1'b0);
            push_b(val < 0 ? "-" : "+", 1'b1, 1'b0);
            mag = (val < 0) ? -val : val;
            for (int d = DIGITS - 1; d >= 0; d--) push_b(8'h30 + 8'((mag / (10 ** d)) % 10), 1'b1, 1'b0);
        end
        push_b(8'h02, 1'b0, 1'b1);
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        logic [9:0] cur, e;
        if (rst_n) begin
            cur = {bus.out_data, bus.out_rs, bus.out_last};
            if (exp_done) begin
                check("done_cycle", {29'h0, bus.done, bus.busy, bus.out_valid}, 32'h4);
                exp_done = 1'b0;
            end
            if (stalled) begin
                check("stall_hold", {21'h0, bus.out_valid, cur}, {21'h0, 1'b1, held});
                stalled = 1'b0;
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_byte");
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {22'h0, cur}, {22'h0, e});
                    end
                    if (bus.out_last) exp_done = 1'b1;
                    xfers++;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
        end
    end

    task automatic send(input int op, input int dest, input int val);
        int n;
        n = 0;
        while (bus.busy && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_now("wait_not_busy");
        bus.start   = 1'b1;
        bus.opcode  = 3'(op);
        bus.destino = DEST_W'(dest);
        bus.valor   = VAL_W'(val);
        push_msg(op, dest, val);
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
        check("first_valid_latency", n, (SHOW_VALUE != 0 && op != 6) ? VAL_W + 1 : 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) fail_now("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        int n, base, v;
        bus.start = 1'b0; bus.opcode = '0; bus.destino = '0; bus.valor = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_done",      bus.done, 0);
        check("rst_out_rs",    bus.out_rs, 0);
        check("rst_out_data",  bus.out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ready_mode = 0; send(0, 4'b1010, -13); wait_idle();
        send(6, 5, 77);  wait_idle();
        ready_mode = 1; send(1, 3, 127); wait_idle();
        ready_mode = 0; send(4, 2, -128); wait_idle();
        send(7, 0, 0);   wait_idle();

        // start while busy must be ignored
        ready_mode = 1; send(1, 9, 55);
        check("busy_mid_message", bus.busy, 1);
        bus.start = 1'b1; bus.opcode = 3'd3; bus.destino = 4'hF; bus.valor = 8'h11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();

        // start in the done cycle is accepted
        ready_mode = 0; send(5, 6, -7);
        n = 0;
        while (!bus.done && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("wait_done");
        bus.start = 1'b1; bus.opcode = 3'd2; bus.destino = 4'd12; bus.valor = 8'd99;
        push_msg(2, 12, 99);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_done_start", bus.busy, 1);
        wait_idle();

        // asynchronous reset while byte 6 is presented
        base = xfers; send(0, 5, 42);
        n = 0;
        while (xfers < base + 6 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("wait_byte6");
        rst_n = 1'b0; #1;
        check("rst_abort_outputs",
              {bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_rs, bus.out_data}, 0);
        exp_q.delete(); exp_done = 1'b0; stalled = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 4'b1010, -13); wait_idle();

        ready_mode = 2;
        repeat (25) begin
            v = int'($urandom_range(0, 255));
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), v > 127 ? v - 256 : v);
        end
        wait_idle();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
